// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: N-requester arbiter with fixed or round-robin priority.
// A grant is held until its owner releases it. The release can be a request
// drop, an acknowledge pulse, or every cycle, depending on the block settings.
// All outputs are registered. There is no combinational path from request to grant.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   request        per-requester request
//   acknowledge    per-requester release pulse (ARB_BLOCK_ACK=1 only)
//   grant          one-hot grant
//   grant_valid    a grant is active
//   grant_encoded  index of the granted port (0 when idle)
//   timeout        one-cycle watchdog pulse (only with ARB_TIMEOUT_EN)
//
// Optional feature: define ARB_TIMEOUT_EN to add a grant watchdog. It forces a
// release after TIMEOUT_CYCLES held cycles and adds the timeout port.
module rr_lock_arbiter #(
  parameter int PORTS                = 4,
  parameter int ARB_TYPE_ROUND_ROBIN = 1,
  parameter int ARB_BLOCK            = 1,
  parameter int ARB_BLOCK_ACK        = 0,
  parameter int LSB_HIGH_PRIORITY    = 1,
  parameter int TIMEOUT_CYCLES       = 256,
  localparam int EW                  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [EW-1:0]    grant_encoded
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

  // Priority encoder: the highest-priority set bit wins.
  function automatic logic [EW-1:0] prio_enc(input logic [PORTS-1:0] v);
    logic [EW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (LSB_HIGH_PRIORITY != 0) begin
        if (v[PORTS-1-i]) idx = EW'(PORTS-1-i);
      end else begin
        if (v[i]) idx = EW'(i);
      end
    end
    return idx;
  endfunction

  state_e           state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [EW-1:0]    enc_q, enc_d;
  logic [PORTS-1:0] mask_q, mask_d;
  logic [PORTS-1:0] req_masked;
  logic [EW-1:0]    win;
  logic             rel_normal;
  logic             rel;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] count_q, count_d;
  logic          timeout_q, timeout_d;
  logic          forced;
`else
  // Without the watchdog, TIMEOUT_CYCLES has no effect on the design.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    enc_d      = enc_q;
    mask_d     = mask_q;
    req_masked = request & mask_q;

    // Round-robin: prefer ports that have lower priority than the last owner.
    // When none of them is requesting, wrap around to the plain encoder.
    if ((ARB_TYPE_ROUND_ROBIN != 0) && (|req_masked)) win = prio_enc(req_masked);
    else                                              win = prio_enc(request);

    if (ARB_BLOCK == 0)          rel_normal = 1'b1;
    else if (ARB_BLOCK_ACK != 0) rel_normal = acknowledge[enc_q];
    else                         rel_normal = !request[enc_q];
    rel = rel_normal;

`ifdef ARB_TIMEOUT_EN
    count_d   = '0;
    forced    = (state_q == ST_GRANTED) && !rel_normal &&
                (count_q == CW'(TIMEOUT_CYCLES - 1));
    rel       = rel_normal | forced;
    timeout_d = forced;
`endif

    if ((state_q == ST_GRANTED) && !rel) begin
`ifdef ARB_TIMEOUT_EN
      count_d = count_q + CW'(1);
`endif
    end else if (|request) begin
      state_d = ST_GRANTED;
      enc_d   = win;
      for (int unsigned i = 0; i < PORTS; i++) begin
        grant_d[i] = (i == 32'(win));
        mask_d[i]  = (LSB_HIGH_PRIORITY != 0) ? (i > 32'(win)) : (i < 32'(win));
      end
    end else begin
      state_d = ST_IDLE;
      grant_d = '0;
      enc_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      enc_q     <= '0;
      mask_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      count_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      enc_q     <= enc_d;
      mask_q    <= mask_d;
`ifdef ARB_TIMEOUT_EN
      count_q   <= count_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = (state_q == ST_GRANTED);
  assign grant_encoded = enc_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout       = timeout_q;
`endif

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter. It drives three instances from shared inputs:
//   0: round-robin, blocking on request (watchdog limit 8)
//   1: fixed priority, no blocking
//   2: round-robin, blocking on acknowledge (watchdog limit 8)
// Each instance is tracked by an ownership model that uses a cyclic search.
module tb_rr_lock_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, ack;
  logic [N-1:0] g_a, g_b, g_c;
  logic         gv_a, gv_b, gv_c;
  logic [1:0]   e_a, e_b, e_c;
`ifdef ARB_TIMEOUT_EN
  logic         to_a, to_b, to_c;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_lock_arbiter #(.PORTS(N), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1),
                    .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1), .TIMEOUT_CYCLES(TO)) dut_a (
    .clk(clk), .rst(rst), .request(req), .acknowledge(ack),
    .grant(g_a), .grant_valid(gv_a), .grant_encoded(e_a)
`ifdef ARB_TIMEOUT_EN
    , .timeout(to_a)
`endif
  );

  rr_lock_arbiter #(.PORTS(N), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0),
                    .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1), .TIMEOUT_CYCLES(TO)) dut_b (
    .clk(clk), .rst(rst), .request(req), .acknowledge(ack),
    .grant(g_b), .grant_valid(gv_b), .grant_encoded(e_b)
`ifdef ARB_TIMEOUT_EN
    , .timeout(to_b)
`endif
  );

  rr_lock_arbiter #(.PORTS(N), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1),
                    .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(1), .TIMEOUT_CYCLES(TO)) dut_c (
    .clk(clk), .rst(rst), .request(req), .acknowledge(ack),
    .grant(g_c), .grant_valid(gv_c), .grant_encoded(e_c)
`ifdef ARB_TIMEOUT_EN
    , .timeout(to_c)
`endif
  );

  // Reference model: owner index (-1 = nobody), last owner, held-cycle count.
  bit cfg_rr[3]    = '{1'b1, 1'b0, 1'b1};
  bit cfg_block[3] = '{1'b1, 1'b0, 1'b1};
  bit cfg_ack[3]   = '{1'b0, 1'b0, 1'b1};
  int m_owner[3]   = '{-1, -1, -1};
  int m_last[3]    = '{N-1, N-1, N-1};
  int m_cnt[3]     = '{0, 0, 0};
  bit m_to[3]      = '{1'b0, 1'b0, 1'b0};

  task automatic model_step(input int i);
    bit rel;
    int o;
    o = m_owner[i];
    m_to[i] = 1'b0;
    if (rst) begin
      m_owner[i] = -1; m_last[i] = N-1; m_cnt[i] = 0;
      return;
    end
    if (o >= 0) begin
      if (!cfg_block[i])   rel = 1'b1;
      else if (cfg_ack[i]) rel = ack[o];
      else                 rel = !req[o];
`ifdef ARB_TIMEOUT_EN
      if (!rel && m_cnt[i] == TO-1) begin rel = 1'b1; m_to[i] = 1'b1; end
`endif
      if (!rel) begin m_cnt[i]++; return; end
    end
    m_cnt[i] = 0;
    m_owner[i] = -1;
    if (req != '0) begin
      if (cfg_rr[i]) begin
        // Search cyclically, starting just after the last owner.
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last[i] + k) % N;
          if (req[c]) begin m_owner[i] = c; break; end
        end
      end else begin
        for (int k = N-1; k >= 0; k--) if (req[k]) m_owner[i] = k;
      end
      m_last[i] = m_owner[i];
    end
  endtask

  task automatic cycle();
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] exp_grant(input int i);
    logic [N-1:0] one;
    one = 4'b0001;
    return (m_owner[i] < 0) ? '0 : (one << m_owner[i]);
  endfunction

  function automatic logic [N-1:0] dut_grant(input int i);
    case (i) 0: return g_a; 1: return g_b; default: return g_c; endcase
  endfunction
  function automatic logic dut_gv(input int i);
    case (i) 0: return gv_a; 1: return gv_b; default: return gv_c; endcase
  endfunction
  function automatic logic [1:0] dut_enc(input int i);
    case (i) 0: return e_a; 1: return e_b; default: return e_c; endcase
  endfunction
`ifdef ARB_TIMEOUT_EN
  function automatic logic dut_to(input int i);
    case (i) 0: return to_a; 1: return to_b; default: return to_c; endcase
  endfunction
`endif

  task automatic do_reset();
    rst = 1'b1; cycle(); rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 4'b1111; ack = '0; rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dut_grant(i) !== 4'b0000 || dut_gv(i) !== 1'b0 || dut_enc(i) !== 2'd0) begin
          errors++;
          $display("FAIL reset_hold inst%0d cyc%0d: grant=%b gv=%b enc=%0d, expected 0000/0/0",
                   i, c, dut_grant(i), dut_gv(i), dut_enc(i));
        end
      end
    end
    rst = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_grant(i) !== 4'b0001 || dut_gv(i) !== 1'b1) begin
        errors++;
        $display("FAIL reset_first inst%0d: grant=%b gv=%b, expected 0001/1", i, dut_grant(i), dut_gv(i));
      end
    end
  endtask

  task automatic test_fixed_priority();
    req = 4'b1010; ack = '0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      checks++;
      if (g_b !== 4'b0010 || e_b !== 2'd1 || gv_b !== 1'b1) begin
        errors++;
        $display("FAIL fixed_prio cyc%0d: grant=%b enc=%0d gv=%b, expected 0010/1/1", c, g_b, e_b, gv_b);
      end
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ack = '0; do_reset();
    req = 4'b1111; cycle();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (g_a !== seq[k] || gv_a !== 1'b1) begin
        errors++;
        $display("FAIL rr_rotation step%0d: grant=%b gv=%b, expected %b/1", k, g_a, gv_a, seq[k]);
      end
      req = 4'b1111 & ~seq[k];
      cycle();
    end
  endtask

  task automatic test_ack_lock();
    ack = '0; do_reset();
    req = 4'b0100; cycle();
    checks++;
    if (g_c !== 4'b0100) begin errors++; $display("FAIL ack_grant2: grant=%b, expected 0100", g_c); end
    req = 4'b1000; cycle();
    checks++;
    if (g_c !== 4'b0100) begin errors++; $display("FAIL ack_hold_reqdrop: grant=%b, expected 0100", g_c); end
    ack = 4'b0001; cycle();
    checks++;
    if (g_c !== 4'b0100) begin errors++; $display("FAIL ack_other_port: grant=%b, expected 0100", g_c); end
    ack = 4'b0100; cycle();
    checks++;
    if (g_c !== 4'b1000 || e_c !== 2'd3) begin
      errors++; $display("FAIL ack_release: grant=%b enc=%0d, expected 1000/3", g_c, e_c);
    end
    ack = '0;
  endtask

  task automatic test_reset_mid_grant();
    ack = '0; do_reset();
    req = 4'b0010; cycle();
    checks++;
    if (g_a !== 4'b0010) begin errors++; $display("FAIL midrst_pre: grant=%b, expected 0010", g_a); end
    req = 4'b1111; rst = 1'b1; cycle(); rst = 1'b0;
    checks++;
    if (g_a !== 4'b0000 || gv_a !== 1'b0) begin
      errors++; $display("FAIL midrst_drop: grant=%b gv=%b, expected 0000/0", g_a, gv_a);
    end
    cycle();
    checks++;
    if (g_a !== 4'b0001) begin errors++; $display("FAIL midrst_mask: grant=%b, expected 0001", g_a); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    ack = '0; do_reset();
    req = 4'b1001;
    for (int c = 1; c <= TO; c++) begin
      cycle();
      checks++;
      if (g_a !== 4'b0001 || to_a !== 1'b0) begin
        errors++; $display("FAIL timeout_hold cyc%0d: grant=%b timeout=%b, expected 0001/0", c, g_a, to_a);
      end
    end
    cycle();
    checks++;
    if (g_a !== 4'b1000 || to_a !== 1'b1) begin
      errors++; $display("FAIL timeout_fire: grant=%b timeout=%b, expected 1000/1", g_a, to_a);
    end
    cycle();
    checks++;
    if (to_a !== 1'b0 || g_a !== 4'b1000) begin
      errors++; $display("FAIL timeout_pulse: grant=%b timeout=%b, expected 1000/0", g_a, to_a);
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] prev;
    prev = '0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      req = ($urandom_range(0, 2) != 0) ? prev : 4'($urandom);
      ack = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      prev = req;
      cycle();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dut_grant(i) !== exp_grant(i) || dut_gv(i) !== (m_owner[i] >= 0) ||
            dut_enc(i) !== ((m_owner[i] < 0) ? 2'd0 : 2'(m_owner[i]))) begin
          errors++;
          $display("FAIL random inst%0d n%0d: grant=%b gv=%b enc=%0d, expected owner %0d (grant %b)",
                   i, n, dut_grant(i), dut_gv(i), dut_enc(i), m_owner[i], exp_grant(i));
        end
`ifdef ARB_TIMEOUT_EN
        checks++;
        if (dut_to(i) !== m_to[i]) begin
          errors++;
          $display("FAIL random_timeout inst%0d n%0d: timeout=%b, expected %b", i, n, dut_to(i), m_to[i]);
        end
`endif
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; ack = '0;
    test_reset();
    test_fixed_priority();
    test_rotation();
    test_ack_lock();
    test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- N-requester arbiter with fixed or round-robin priority.
- Grant is held until the requester releases it (request drop or acknowledge).
- Built on the team's priority_encoder; used to share an AXI master or interconnect port among several requesters.
- All grant outputs are registered. One clock domain.

Parameters:
- PORTS, 4, number of requesters (≥1).
- ARB_TYPE_ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority.
- ARB_BLOCK, 1, 1 = hold grant while the granted request stays high; 0 = re-arbitrate every cycle.
- ARB_BLOCK_ACK, 0, 1 = hold grant until acknowledge pulse (needs ARB_BLOCK=1).
- LSB_HIGH_PRIORITY, 1, 1 = lower index wins ties; 0 = higher index wins.
- TIMEOUT_CYCLES, 256, grant watchdog limit. Used only with ARB_TIMEOUT_EN.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- request, input, PORTS, per-requester request.
- acknowledge, input, PORTS, per-requester release pulse. Used when ARB_BLOCK_ACK=1.
- grant, output, PORTS, one-hot grant.
- grant_valid, output, 1, some grant active.
- grant_encoded, output, $clog2(PORTS) (min 1), index of the granted port.
- timeout, output, 1, one-cycle watchdog pulse. Port exists only with ARB_TIMEOUT_EN.

Behaviour:
- Interface (decided): one clock `clk`; `rst` is synchronous and active-high.
- Reset: grant=0, grant_valid=0, grant_encoded=0, mask=0, timeout=0, counter=0.
- Reset mid-grant drops the grant on the next edge. First arbitration happens in the cycle after rst deasserts.
- Latency: request sampled at edge k gives grant visible after edge k (one registered cycle). No combinational path from request to grant.
- Two states:
  - IDLE: grant_valid=0.
  - GRANTED: exactly one grant bit set; grant_encoded matches it.
- Release condition for granted port g:
  - ARB_BLOCK=0: release every cycle.
  - ARB_BLOCK=1, ARB_BLOCK_ACK=0: release when request[g]=0.
  - ARB_BLOCK_ACK=1: release when acknowledge[g]=1. request[g] is ignored while granted.
- Each cycle:
  - If GRANTED and not releasing: hold the grant unchanged.
  - Otherwise: arbitrate over the current request vector.
    - If any request is set: GRANTED to the winner.
    - Else: IDLE, and grant, grant_valid and grant_encoded go to 0.
  - On release with other requests pending, the next owner's grant appears on the same edge that removes the old grant. No idle bubble.
- Fixed priority: winner is the priority_encoder result over request (LSB_HIGH_PRIORITY picks direction).
- Round-robin:
  - On every new grant to index g, mask is set to bits strictly lower priority than g (index > g when LSB_HIGH_PRIORITY=1).
  - Winner is the encoder result over request&mask if that is nonzero, else over request.
  - The releasing port may be re-granted only if no other port requests.
- acknowledge on a non-granted port is ignored. acknowledge with no grant is ignored.
- Release and the same port re-requesting in the same cycle: treated as a release. Round-robin may move to another port.
- PORTS=1: grant equals the registered request, subject to the block rules. grant_encoded is always 0.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on each new grant and increments each cycle a grant is held.
  - When it reaches TIMEOUT_CYCLES-1 while the grant is still held, a forced release occurs: grant drops exactly as for a normal release, with re-arbitration on the same edge.
  - timeout pulses 1 for one cycle, aligned with the new grant state.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- Undefined: no counter, no timeout port; a grant may be held indefinitely.

Test Plan:
- Reset: rst=1 for 3 cycles with request=4'b1111 -> grant=0 and grant_valid=0 throughout; grant=4'b0001 one cycle after rst falls.
- Fixed priority (ARB_TYPE_ROUND_ROBIN=0, ARB_BLOCK=0): request=4'b1010 held -> grant=4'b0010 every cycle, grant_encoded=1.
- Round-robin rotation (ARB_BLOCK=1): request=4'b1111; drop request[granted] for one cycle after each grant -> grant sequence 0001, 0010, 0100, 1000, 0001, with no idle cycle between owners.
- Acknowledge lock (ARB_BLOCK_ACK=1): port 2 granted and request[2] drops -> grant held; acknowledge[0] pulse -> still held; acknowledge[2] pulse -> next edge grants the pending port 3 (grant=4'b1000).
- Reset mid-grant: port 1 granted, rst pulsed for 1 cycle -> grant=0 on that edge; mask cleared, so after rst falls with request=4'b1111 the grant is 4'b0001.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: port 0 holds its request, port 3 also requesting -> port 0 granted for exactly 8 cycles, timeout=1 for one cycle, grant=4'b1000 on that same edge.
